calc_ctrl: RTL

Key-sequencing controller for the calculator datapath. Builds operands from keypad digit codes and tracks the pending operator. Runs the arithmetic: add, subtract and multiply in one cycle, divide with an iterative restoring divider. Presents a single 14-bit value and flags to the display stage. Sits between the debounced key decoder and the 7-segment display driver.

---
 rtl/calc_ctrl.sv | 278 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/calc_ctrl.sv
// ---------------------------------------------------------------------------
// calc_ctrl -- key-sequencing controller for the calculator datapath.
//
// Builds two decimal operands (0..9999) from keypad digit codes, tracks the
// pending operator and runs the arithmetic. Add, subtract and multiply finish
// one cycle after the triggering key. Divide uses a 14-iteration restoring
// divider that produces one quotient bit per cycle. A single 14-bit value and
// status flags are presented to the 7-segment display stage.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   key_valid  in   one-cycle strobe, key_num valid
//   key_num    in   [3:0] 0-9 digit, 10 add, 11 sub, 12 mul, 13 div,
//                   14 equals, 15 clear
//   key_ready  out  a non-clear key will be accepted (low while computing)
//   disp_val   out  [13:0] operand being entered, or result
//   disp_sel   out  0 = operand A / result shown, 1 = operand B shown
//   op_flag    out  [3:0] pending operator code 10-13, 0 = none
//   busy       out  high while a computation is running
//   done       out  one-cycle pulse when a result is written
//   err        out  sticky error, cleared only by clear key or rst
// ---------------------------------------------------------------------------
module calc_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_num,
  output logic        key_ready,
  output logic [13:0] disp_val,
  output logic        disp_sel,
  output logic [3:0]  op_flag,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [13:0] MAX_VAL  = 14'd9999;
  localparam logic [3:0]  KEY_ADD  = 4'd10;
  localparam logic [3:0]  KEY_SUB  = 4'd11;
  localparam logic [3:0]  KEY_MUL  = 4'd12;
  localparam logic [3:0]  KEY_DIV  = 4'd13;
  localparam logic [3:0]  KEY_EQ   = 4'd14;
  localparam logic [3:0]  KEY_CLR  = 4'd15;
  // Iteration index of the last quotient bit (14 iterations, 0..13).
  localparam logic [3:0]  DIV_LAST = 4'd13;

  typedef enum logic [2:0] {
    ENTER_A,
    OP_WAIT,
    ENTER_B,
    EXEC,
    RESULT,
    ERROR
  } state_t;

  state_t      state_reg;
  logic [13:0] a_reg;
  logic [13:0] b_reg;
  logic [3:0]  op_flag_reg;
  logic [3:0]  next_op_reg;
  logic [13:0] rem_reg;
  logic [13:0] quo_reg;
  logic [3:0]  div_cnt_reg;
  logic [13:0] disp_val_reg;
  logic        disp_sel_reg;
  logic        busy_reg;
  logic        done_reg;
  logic        err_reg;
  logic        key_ready_reg;

  assign key_ready = key_ready_reg;
  assign disp_val  = disp_val_reg;
  assign disp_sel  = disp_sel_reg;
  assign op_flag   = op_flag_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign err       = err_reg;

  // Key classification
  logic is_digit;
  logic is_oper;
  logic is_equals;
  logic clear_key;
  logic key_take;

  assign is_digit  = (key_num <= 4'd9);
  assign is_oper   = (key_num >= KEY_ADD) && (key_num <= KEY_DIV);
  assign is_equals = (key_num == KEY_EQ);
  assign clear_key = key_valid && (key_num == KEY_CLR);
  assign key_take  = key_valid && key_ready_reg;

  // Digit append: operand*10 + d, kept wide enough to detect overflow.
  logic [16:0] a_append;
  logic [16:0] b_append;
  logic        a_fits;
  logic        b_fits;

  assign a_append = ({3'd0, a_reg} * 17'd10) + {13'd0, key_num};
  assign b_append = ({3'd0, b_reg} * 17'd10) + {13'd0, key_num};
  assign a_fits   = (a_append <= {3'd0, MAX_VAL});
  assign b_fits   = (b_append <= {3'd0, MAX_VAL});

  // Single-cycle arithmetic
  logic [14:0] sum;
  logic [27:0] prod;

  assign sum  = {1'b0, a_reg} + {1'b0, b_reg};
  assign prod = {14'd0, a_reg} * {14'd0, b_reg};

  // Restoring divider step: shift the next dividend bit into the partial
  // remainder and subtract the divisor when it fits. The dividend lives in
  // quo_reg and is shifted out as quotient bits are shifted in.
  logic [14:0] div_shift;
  logic        div_ge;
  logic [13:0] div_diff;
  logic [13:0] rem_next;
  logic [13:0] quo_next;

  assign div_shift = {rem_reg, quo_reg[13]};
  assign div_ge    = (div_shift >= {1'b0, b_reg});
  // When div_ge holds the true difference is below b_reg, so 14 bits suffice.
  assign div_diff  = div_shift[13:0] - b_reg;
  assign rem_next  = div_ge ? div_diff : div_shift[13:0];
  assign quo_next  = {quo_reg[12:0], div_ge};

  // Outcome of the operation pending in EXEC
  logic [13:0] exec_result;
  logic        exec_err;
  logic        exec_last;

  always_comb begin
    exec_result = 14'd0;
    exec_err    = 1'b0;
    case (op_flag_reg)
      KEY_ADD: begin
        exec_result = sum[13:0];
        exec_err    = (sum > {1'b0, MAX_VAL});
      end
      KEY_SUB: begin
        exec_result = a_reg - b_reg;
        exec_err    = (a_reg < b_reg);
      end
      KEY_MUL: begin
        exec_result = prod[13:0];
        exec_err    = (prod > {14'd0, MAX_VAL});
      end
      KEY_DIV: begin
        exec_result = quo_next;
        exec_err    = (b_reg == 14'd0);
      end
      default: begin
        exec_result = 14'd0;
        exec_err    = 1'b0;
      end
    endcase
    exec_last = (op_flag_reg != KEY_DIV) || (div_cnt_reg == DIV_LAST);
  end

  always_ff @(posedge clk) begin
    // Reset and the clear key produce identical state, so one branch covers
    // both; clear is honoured in every state, including mid-computation.
    if (rst || clear_key) begin
      state_reg     <= ENTER_A;
      a_reg         <= 14'd0;
      b_reg         <= 14'd0;
      op_flag_reg   <= 4'd0;
      next_op_reg   <= 4'd0;
      rem_reg       <= 14'd0;
      quo_reg       <= 14'd0;
      div_cnt_reg   <= 4'd0;
      disp_val_reg  <= 14'd0;
      disp_sel_reg  <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
      key_ready_reg <= 1'b1;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ENTER_A: begin
          if (key_take) begin
            if (is_digit) begin
              if (a_fits) begin
                a_reg        <= a_append[13:0];
                disp_val_reg <= a_append[13:0];
              end
            end else if (is_oper) begin
              op_flag_reg <= key_num;
              state_reg   <= OP_WAIT;
            end
          end
        end

        OP_WAIT: begin
          if (key_take) begin
            if (is_digit) begin
              b_reg        <= {10'd0, key_num};
              disp_val_reg <= {10'd0, key_num};
              disp_sel_reg <= 1'b1;
              state_reg    <= ENTER_B;
            end else if (is_oper) begin
              op_flag_reg <= key_num;
            end
          end
        end

        ENTER_B: begin
          if (key_take) begin
            if (is_digit) begin
              if (b_fits) begin
                b_reg        <= b_append[13:0];
                disp_val_reg <= b_append[13:0];
              end
            end else if (is_oper || is_equals) begin
              // Chained operator becomes pending after this result.
              next_op_reg   <= is_oper ? key_num : 4'd0;
              rem_reg       <= 14'd0;
              quo_reg       <= a_reg;
              div_cnt_reg   <= 4'd0;
              busy_reg      <= 1'b1;
              key_ready_reg <= 1'b0;
              state_reg     <= EXEC;
            end
          end
        end

        EXEC: begin
          if (exec_err) begin
            err_reg       <= 1'b1;
            disp_val_reg  <= 14'd0;
            disp_sel_reg  <= 1'b0;
            op_flag_reg   <= 4'd0;
            busy_reg      <= 1'b0;
            key_ready_reg <= 1'b1;
            state_reg     <= ERROR;
          end else if (exec_last) begin
            a_reg         <= exec_result;
            b_reg         <= 14'd0;
            disp_val_reg  <= exec_result;
            disp_sel_reg  <= 1'b0;
            op_flag_reg   <= next_op_reg;
            done_reg      <= 1'b1;
            busy_reg      <= 1'b0;
            key_ready_reg <= 1'b1;
            state_reg     <= (next_op_reg != 4'd0) ? OP_WAIT : RESULT;
          end else begin
            rem_reg     <= rem_next;
            quo_reg     <= quo_next;
            div_cnt_reg <= div_cnt_reg + 4'd1;
          end
        end

        RESULT: begin
          if (key_take) begin
            if (is_digit) begin
              a_reg        <= {10'd0, key_num};
              disp_val_reg <= {10'd0, key_num};
              state_reg    <= ENTER_A;
            end else if (is_oper) begin
              op_flag_reg <= key_num;
              state_reg   <= OP_WAIT;
            end
          end
        end

        ERROR: begin
          // Only clear leaves this state.
        end

        default: begin
          state_reg <= ENTER_A;
        end
      endcase
    end
  end

endmodule
